div16_seq: RTL and testbench

- Multi-cycle restoring integer divider for the 16-bit CPU execute stage.
- Sequences one shared (N+1)-bit borrow-subtract step over N iterations and produces one quotient bit per cycle.
- Sits beside the ALU. The CPU control unit issues a start pulse, stalls while busy, and captures the results on done.

---
 rtl/cpu_alu_pkg.sv | 14 +
 rtl/div16_seq_if.sv | 23 ++
 rtl/sub_step.sv | 17 +
 rtl/div16_seq.sv | 161 ++++++++++++++++
 tb/tb_div16_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the CPU multi-cycle ALU operations.
package cpu_alu_pkg;

  localparam int unsigned N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [N-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div16_seq_if.sv
// Start/result handshake between the CPU control unit (master) and the divider (slave).
interface div16_seq_if #(parameter int unsigned N = cpu_alu_pkg::N) ();

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sub_step.sv
// Combinational W-bit subtractor exposing the borrow-out, shared by multi-cycle ALU ops.
module sub_step #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] full;

  assign full       = {1'b0, a} - {1'b0, b};
  assign diff       = full[W-1:0];
  assign borrow_out = full[W];

endmodule

// File: rtl/div16_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Optional two's-complement operation under `define SIGNED_DIV_EN.
module div16_seq
  import cpu_alu_pkg::*;
#(
  parameter int unsigned N  = cpu_alu_pkg::N,
  parameter int unsigned CW = 5
) (
  input logic        clk,
  input logic        rst,
  div16_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_CALC = 2'(CALC);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]    state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [N-1:0]  q_sr, q_sr_nx;
  logic [N-1:0]  r_sr, r_sr_nx;
  logic [N-1:0]  d_r, d_r_nx;
  logic          busy_r, busy_nx;
  logic          done_r, done_nx;
  logic [N-1:0]  quot_r, quot_nx;
  logic [N-1:0]  rem_r, rem_nx;
  logic          dbz_r, dbz_nx;

  logic [N:0]    trial_a, trial_b, trial_diff;
  logic          trial_borrow;
  logic [N-1:0]  step_q, step_r;
  logic [N-1:0]  mag_a, mag_b, fin_q, fin_r;

  // One shift-subtract iteration: partial remainder with the next dividend bit minus divisor
  assign trial_a = {r_sr, q_sr[N-1]};
  assign trial_b = {1'b0, d_r};

  sub_step #(.W(N + 1)) u_step (
    .a          (trial_a),
    .b          (trial_b),
    .diff       (trial_diff),
    .borrow_out (trial_borrow)
  );

  assign step_q = {q_sr[N-2:0], ~trial_borrow};
  assign step_r = trial_borrow ? trial_a[N-1:0] : trial_diff[N-1:0];

`ifdef SIGNED_DIV_EN
  logic sign_q, sign_q_nx;
  logic sign_r, sign_r_nx;

  // -2^(N-1) negates to itself, which reads correctly as an unsigned magnitude
  assign mag_a = bus.dividend[N-1] ? (~bus.dividend + N'(1)) : bus.dividend;
  assign mag_b = bus.divisor[N-1]  ? (~bus.divisor  + N'(1)) : bus.divisor;
  assign fin_q = sign_q ? (~step_q + N'(1)) : step_q;
  assign fin_r = sign_r ? (~step_r + N'(1)) : step_r;
`else
  assign mag_a = bus.dividend;
  assign mag_b = bus.divisor;
  assign fin_q = step_q;
  assign fin_r = step_r;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    count_nx = count;
    q_sr_nx  = q_sr;
    r_sr_nx  = r_sr;
    d_r_nx   = d_r;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    quot_nx  = quot_r;
    rem_nx   = rem_r;
    dbz_nx   = dbz_r;
`ifdef SIGNED_DIV_EN
    sign_q_nx = sign_q;
    sign_r_nx = sign_r;
`endif
    case (state)
      S_CALC: begin
        q_sr_nx  = step_q;
        r_sr_nx  = step_r;
        count_nx = count + CW'(1);
        if (count == CW'(N - 1)) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          quot_nx  = fin_q;
          rem_nx   = fin_r;
          dbz_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
            quot_nx  = DIV0_QUOTIENT;
            rem_nx   = bus.dividend;
            dbz_nx   = 1'b1;
          end else begin
            state_nx = S_CALC;
            busy_nx  = 1'b1;
            count_nx = '0;
            q_sr_nx  = mag_a;
            r_sr_nx  = '0;
            d_r_nx   = mag_b;
`ifdef SIGNED_DIV_EN
            sign_q_nx = bus.dividend[N-1] ^ bus.divisor[N-1];
            sign_r_nx = bus.dividend[N-1];
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      q_sr   <= '0;
      r_sr   <= '0;
      d_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q <= 1'b0;
      sign_r <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      q_sr   <= q_sr_nx;
      r_sr   <= r_sr_nx;
      d_r    <= d_r_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
      quot_r <= quot_nx;
      rem_r  <= rem_nx;
      dbz_r  <= dbz_nx;
`ifdef SIGNED_DIV_EN
      sign_q <= sign_q_nx;
      sign_r <= sign_r_nx;
`endif
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: vector table, corner sequences, random ops vs. arithmetic model.
module tb_div16_seq;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div16_seq_if bus ();

  div16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z);
`ifdef SIGNED_DIV_EN
    int sa, sb, qi, ri;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      q  = N'(qi);
      r  = N'(ri);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Called at a negedge right after start was removed; counts edges until done.
  task automatic wait_done(input int inj_at, output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int m = 0; m < 40; m++) begin
      if (bus.done) begin
        lat = m;
        return;
      end
      if (bus.busy) busy_n++;
      if (m == inj_at) begin
        bus.start    = 1'b1;
        bus.dividend = 16'h1111;
        bus.divisor  = 16'h0003;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // Must be called at a negedge; drives a one-cycle start.
  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input int inj_at,
                     output int lat, output int busy_n);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(inj_at, lat, busy_n);
  endtask

  task automatic check_op(input string tag, input logic [N-1:0] b, input logic [N-1:0] q,
                          input logic [N-1:0] r, input logic z, input int lat, input int busy_n);
    int exp_lat;
    exp_lat = (b == '0) ? 0 : 16;
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'(0));
    check({tag, ".quotient"}, 32'(bus.quotient), 32'(q));
    check({tag, ".remainder"}, 32'(bus.remainder), 32'(r));
    check({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(z));
  endtask

  vec_t vecs[$];

  initial begin
    int lat, busy_n;
    logic [N-1:0] a, b, eq, er;
    logic ez;

    vecs.push_back('{16'd100,   16'd7,      16'd14,     16'd2,      1'b0});
    vecs.push_back('{16'd50,    16'd5,      16'd10,     16'd0,      1'b0});
    vecs.push_back('{16'h1234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1});
    vecs.push_back('{16'd0,     16'd3,      16'd0,      16'd0,      1'b0});
    vecs.push_back('{16'd5,     16'd9,      16'd0,      16'd5,      1'b0});
    vecs.push_back('{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0});
`ifdef SIGNED_DIV_EN
    vecs.push_back('{16'hFFF9,  16'd2,      16'hFFFD,   16'hFFFF,   1'b0});
    vecs.push_back('{16'd7,     16'hFFFE,   16'hFFFD,   16'h0001,   1'b0});
    vecs.push_back('{16'h8000,  16'hFFFF,   16'h8000,   16'h0000,   1'b0});
`else
    vecs.push_back('{16'hFFFF,  16'hFFFF,   16'h0001,   16'h0000,   1'b0});
    vecs.push_back('{16'h8000,  16'hFFFF,   16'h0000,   16'h8000,   1'b0});
    vecs.push_back('{16'hFFFE,  16'h8000,   16'h0001,   16'h7FFE,   1'b0});
`endif

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    check("reset.busy", 32'(bus.busy), 32'(0));
    check("reset.done", 32'(bus.done), 32'(0));
    check("reset.quotient", 32'(bus.quotient), 32'(0));
    check("reset.remainder", 32'(bus.remainder), 32'(0));
    check("reset.div_by_zero", 32'(bus.div_by_zero), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i].a, vecs[i].b, -1, lat, busy_n);
      check_op($sformatf("vec%0d", i), vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, lat, busy_n);
      @(negedge clk);
      check($sformatf("vec%0d.done_pulse", i), 32'(bus.done), 32'(0));
    end

    // Back-to-back issue in the DONE cycle
    run(16'hFFFF, 16'h0001, -1, lat, busy_n);
    check_op("b2b_first", 16'h0001, 16'hFFFF, 16'h0000, 1'b0, lat, busy_n);
    run(16'h0005, 16'h0009, -1, lat, busy_n);
    check_op("b2b_second", 16'h0009, 16'h0000, 16'h0005, 1'b0, lat, busy_n);
    @(negedge clk);

    // start with new operands during CALC is ignored
    run(16'd100, 16'd7, 5, lat, busy_n);
    check_op("ignore_start", 16'd7, 16'd14, 16'd2, 1'b0, lat, busy_n);
    @(negedge clk);
    check("ignore_start.idle_after", 32'(bus.busy), 32'(0));

    // Asynchronous reset in the middle of CALC
    bus.start    = 1'b1;
    bus.dividend = 16'hABCD;
    bus.divisor  = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("midcalc.busy_before_rst", 32'(bus.busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("midcalc_rst.busy", 32'(bus.busy), 32'(0));
    check("midcalc_rst.quotient", 32'(bus.quotient), 32'(0));
    check("midcalc_rst.remainder", 32'(bus.remainder), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst.done", 32'(bus.done), 32'(0));
    run(16'd50, 16'd5, -1, lat, busy_n);
    check_op("after_rst", 16'd5, 16'd10, 16'd0, 1'b0, lat, busy_n);
    @(negedge clk);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = N'($urandom_range(1, 15));
        default: b = N'($urandom);
      endcase
      ref_div(a, b, eq, er, ez);
      run(a, b, -1, lat, busy_n);
      check_op($sformatf("rand%0d", i), b, eq, er, ez, lat, busy_n);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
